// File: rtl/branch_pkg.sv
// Shared types and defaults for the fetch-stage branch prediction slice.
package branch_pkg;

    localparam int unsigned BTB_ENTRIES_DEFAULT = 64;
    localparam int unsigned BTB_IDX_DEFAULT     = $clog2(BTB_ENTRIES_DEFAULT);

    // Tag is pc[31:IDX+2] zero-extended to a fixed width, so the entry type does not
    // depend on the BTB depth; constant-zero upper bits are trimmed by synthesis.
    localparam int unsigned TAG_W = 30;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:0]      target;
    } btb_entry_t;

    typedef logic [0:0] fetch_state_e;
    localparam fetch_state_e BOOT = 1'b0;
    localparam fetch_state_e RUN  = 1'b1;

    function automatic logic [TAG_W-1:0] pc_tag(input logic [31:0] pc, input int unsigned idx_w);
        return TAG_W'(pc >> (idx_w + 2));
    endfunction

endpackage

// File: rtl/btb_store.sv
// Direct-mapped BTB storage: async read, sync write, valid bits cleared on reset.
module btb_store
    import branch_pkg::*;
#(
    parameter int unsigned ENTRIES = BTB_ENTRIES_DEFAULT,
    parameter int unsigned IDX     = BTB_IDX_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [IDX-1:0] rd_idx_i,
    output btb_entry_t     rd_entry_o,
    input  logic           wr_en_i,
    input  logic [IDX-1:0] wr_idx_i,
    input  btb_entry_t     wr_entry_i
);

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];

    always_comb begin
        valid_d = valid_q;
        if (wr_en_i) begin
            valid_d[wr_idx_i] = wr_entry_i.valid;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tags and targets carry no reset; the valid bit alone qualifies them.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i]    <= wr_entry_i.tag;
            target_q[wr_idx_i] <= wr_entry_i.target;
        end
    end

    always_comb begin
        rd_entry_o.valid  = valid_q[rd_idx_i];
        rd_entry_o.tag    = tag_q[rd_idx_i];
        rd_entry_o.target = target_q[rd_idx_i];
    end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch-stage next-PC generator: BHT+BTB prediction, mispredict redirect, BTB training
// and branch statistics.
module fetch_pc_gen
    import branch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned BTB_ENTRIES = BTB_ENTRIES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        predict_taken_i,
    input  logic        ex_valid_i,
    input  logic        ex_is_branch_i,
    input  logic [31:0] ex_pc_i,
    input  logic        ex_taken_i,
    input  logic [31:0] ex_target_i,
    input  logic        ex_pred_taken_i,
    input  logic [31:0] ex_pred_target_i,
    output logic [31:0] fetch_pc_o,
    output logic        fetch_valid_o,
    output logic        pred_taken_o,
    output logic [31:0] pred_target_o,
    output logic        redirect_o,
    output logic [31:0] branch_count_o,
    output logic [31:0] mispredict_count_o
);

    localparam int unsigned IDX = $clog2(BTB_ENTRIES);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  branch_cnt_q, branch_cnt_d;
    logic [31:0]  mp_cnt_q, mp_cnt_d;

    btb_entry_t     rd_entry, wr_entry;
    logic [IDX-1:0] rd_idx, wr_idx;
    logic           btb_hit, ex_branch, train, mp;
    logic [31:0]    correct_pc;

    btb_store #(
        .ENTRIES (BTB_ENTRIES),
        .IDX     (IDX)
    ) u_btb (
        .clk        (clk),
        .rst        (rst),
        .rd_idx_i   (rd_idx),
        .rd_entry_o (rd_entry),
        .wr_en_i    (train),
        .wr_idx_i   (wr_idx),
        .wr_entry_i (wr_entry)
    );

    always_comb begin
        rd_idx        = pc_q[IDX+1:2];
        btb_hit       = rd_entry.valid && (rd_entry.tag == pc_tag(pc_q, IDX));
        pred_taken_o  = predict_taken_i && btb_hit;
        pred_target_o = pred_taken_o ? rd_entry.target : pc_q + 32'd4;
    end

    always_comb begin
        ex_branch  = ex_valid_i && ex_is_branch_i;
        mp         = ex_branch && ((ex_taken_i != ex_pred_taken_i) ||
                                   (ex_taken_i && (ex_target_i != ex_pred_target_i)));
        correct_pc = ex_taken_i ? ex_target_i : ex_pc_i + 32'd4;

        train           = ex_branch && ex_taken_i;
        wr_idx          = ex_pc_i[IDX+1:2];
        wr_entry.valid  = 1'b1;
        wr_entry.tag    = pc_tag(ex_pc_i, IDX);
        wr_entry.target = ex_target_i;
    end

    // A mispredict wins over stall: the stalled instruction is on the wrong path anyway.
    always_comb begin
        state_d = RUN;
        if (mp) begin
            pc_d = correct_pc;
        end else if (stall_i || state_q == BOOT) begin
            pc_d = pc_q;
        end else begin
            pc_d = pred_target_o;
        end
        branch_cnt_d = ex_branch ? branch_cnt_q + 32'd1 : branch_cnt_q;
        mp_cnt_d     = mp ? mp_cnt_q + 32'd1 : mp_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= BOOT;
            pc_q         <= RESET_PC;
            branch_cnt_q <= '0;
            mp_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            branch_cnt_q <= branch_cnt_d;
            mp_cnt_q     <= mp_cnt_d;
        end
    end

    always_comb begin
        fetch_pc_o         = pc_q;
        fetch_valid_o      = (state_q == RUN);
        redirect_o         = mp;
        branch_count_o     = branch_cnt_q;
        mispredict_count_o = mp_cnt_q;
    end

endmodule
